// File: rtl/output_classifier_pkg.sv
// Shared types for the output classifier: score/diff widths and the queued result record.
package output_classifier_pkg;
    localparam int SCORE_W  = 17;
    localparam int MARGIN_W = 12;

    typedef logic signed [SCORE_W:0] diff_t;

    typedef struct packed {
        logic                cls;
        logic [MARGIN_W-1:0] margin;
        logic                low_conf;
    } class_res_t;

    function automatic diff_t score_diff(input logic signed [SCORE_W-1:0] a,
                                         input logic signed [SCORE_W-1:0] b);
        return diff_t'(a) - diff_t'(b);
    endfunction
endpackage

// File: rtl/output_classifier_result_fifo.sv
// Small circular result queue; a pop in the same cycle frees room for a push into a full queue.
module result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_cnt;
    logic          w_do_pop, w_do_push;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_dout    = o_empty ? '0 : r_mem[r_rd];

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/output_classifier.sv
// Pairs the two output-neuron scores, decides argmax with a saturated margin, queues results
// and keeps sticky error flags plus per-class saturating counters.
module output_classifier
    import output_classifier_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int MIN_MARGIN = 16,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [SCORE_W-1:0]  i_in0,
    input  logic signed [SCORE_W-1:0]  i_in1,
    input  logic                       i_in0_ready,
    input  logic                       i_in1_ready,
    output logic                       o_res_valid,
    output logic                       o_res_class,
    output logic [MARGIN_W-1:0]        o_res_margin,
    output logic                       o_res_low_conf,
    input  logic                       i_res_ack,
    input  logic                       i_stat_clr,
    output logic                       o_overflow,
    output logic                       o_pair_err,
    output logic [CNT_W-1:0]           o_cnt0,
    output logic [CNT_W-1:0]           o_cnt1
);
    localparam logic [SCORE_W:0] MAX_MARGIN = (SCORE_W+1)'((1 << MARGIN_W) - 1);

    logic signed [SCORE_W-1:0] r_d0, r_d1;
    logic                      r_full0, r_full1;
    logic                      r_overflow, r_pair_err;
    logic [CNT_W-1:0]          r_cnt0, r_cnt1;

    logic                      w_pair, w_pop, w_full, w_empty, w_accept;
    diff_t                     w_diff;
    logic [SCORE_W:0]          w_mag;
    class_res_t                w_res, w_head;
    logic [$bits(class_res_t)-1:0] w_dout;

    assign w_pair = r_full0 & r_full1;
    assign w_diff = score_diff(r_d0, r_d1);
    assign w_mag  = w_diff[SCORE_W] ? $unsigned(-w_diff) : $unsigned(w_diff);

    always_comb begin
        w_res          = '0;
        w_res.cls      = w_diff[SCORE_W];
        w_res.margin   = (w_mag > MAX_MARGIN) ? '1 : w_mag[MARGIN_W-1:0];
        w_res.low_conf = (w_mag < (SCORE_W+1)'(MIN_MARGIN));
    end

    assign w_pop    = i_res_ack & ~w_empty;
    assign w_accept = w_pair & (~w_full | w_pop);

    result_fifo #(.DEPTH(DEPTH), .W($bits(class_res_t))) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_pair),
        .i_pop   (w_pop),
        .i_din   (w_res),
        .o_dout  (w_dout),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign w_head         = class_res_t'(w_dout);
    assign o_res_valid    = ~w_empty;
    assign o_res_class    = w_head.cls;
    assign o_res_margin   = w_head.margin;
    assign o_res_low_conf = w_head.low_conf;
    assign o_overflow     = r_overflow;
    assign o_pair_err     = r_pair_err;
    assign o_cnt0         = r_cnt0;
    assign o_cnt1         = r_cnt1;

    // A ready landing in the push cycle refills its slot rather than being lost to the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0    <= '0;
            r_d1    <= '0;
            r_full0 <= 1'b0;
            r_full1 <= 1'b0;
        end else begin
            if (i_in0_ready) r_d0 <= i_in0;
            if (i_in1_ready) r_d1 <= i_in1;
            r_full0 <= i_in0_ready | (r_full0 & ~w_pair);
            r_full1 <= i_in1_ready | (r_full1 & ~w_pair);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_pair_err <= 1'b0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
        end else if (i_stat_clr) begin
            r_overflow <= 1'b0;
            r_pair_err <= 1'b0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
        end else begin
            if (w_pair & ~w_accept) r_overflow <= 1'b1;
            if ((i_in0_ready & r_full0 & ~w_pair) | (i_in1_ready & r_full1 & ~w_pair))
                r_pair_err <= 1'b1;
            if (w_accept & ~w_res.cls & (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_accept &  w_res.cls & (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end
endmodule

// File: doc/output_classifier.md
Name: output_classifier

Overview:
- Sits directly downstream of the two-neuron output layer.
- Captures the two 17-bit signed neuron results, each qualified by its own single-cycle ready pulse, and pairs them.
- Computes an argmax class decision plus a saturated confidence margin, and queues each result in a small FIFO for a valid/ack consumer.
- Keeps sticky error flags and per-class saturating counters.

Parameters:
- DEPTH, 4, result FIFO entries (power of 2, >=2).
- MARGIN_W, 12, width of reported margin; saturates at 2^MARGIN_W-1.
- MIN_MARGIN, 16, margin strictly below this sets low_conf.
- CNT_W, 16, width of per-class saturating counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in0  input  17  signed score, class 0.
- in1  input  17  signed score, class 1.
- in0_ready  input  1  single-cycle strobe qualifying in0.
- in1_ready  input  1  single-cycle strobe qualifying in1.
- res_valid  output  1  FIFO head holds a result.
- res_class  output  1  head class id (0/1).
- res_margin  output  MARGIN_W  head |in0-in1|, saturated.
- res_low_conf  output  1  head margin < MIN_MARGIN.
- res_ack  input  1  pop head; ignored when res_valid=0.
- stat_clr  input  1  synchronous clear of counters and sticky flags.
- overflow  output  1  sticky: result dropped because FIFO was full.
- pair_err  output  1  sticky: a ready arrived while its own slot was already full.
- cnt0, cnt1  output  CNT_W each  saturating counts of results pushed with class 0 / class 1.

Behaviour:
- Reset (rst_n low, asynchronous): both capture slots empty; FIFO empty.
  - res_valid=0, res_class=0, res_margin=0, res_low_conf=0.
  - overflow=0, pair_err=0, cnt0=0, cnt1=0.
- Capture stage: each of slot0 and slot1 has a 17-bit data register and a full bit.
  - inX_ready high in cycle C loads slotX at the end of C and sets fullX.
  - If slotX is already full, the new value overwrites it and pair_err sets.
  - in0_ready and in1_ready may arrive in the same cycle or any number of cycles apart.
- Compare/push stage: when full0 && full1 at the start of cycle P, the result is computed combinationally from the slots and pushed at the end of P.
  - Both full bits clear at the end of P.
  - A ready arriving in cycle P for a slot being cleared is captured: capture wins over clear, and that full bit stays set. This does not set pair_err.
- Arithmetic:
  - diff = in0 - in1, computed at 18 bits signed.
  - res_class = 1 iff in1 > in0; a tie gives class 0.
  - mag = |diff|, 18 bits unsigned; res_margin = min(mag, 2^MARGIN_W-1).
  - res_low_conf = (mag < MIN_MARGIN), evaluated on the unsaturated mag.
- Latency: both readies in cycle C, push in C+1, res_valid=1 in C+2 when the FIFO was empty. The outputs are driven registered from the FIFO head.
- FIFO: DEPTH entries, each {class, margin, low_conf}.
  - Pop occurs when res_ack && res_valid at a clock edge.
  - Push and pop in the same cycle are both performed; when full, the pop frees the slot and the push is accepted.
  - Push when full without a same-cycle pop: the result is discarded and overflow sets. Slots still clear, and counters do not increment.
  - Pointers wrap modulo DEPTH; an occupancy counter of log2(DEPTH)+1 bits tracks level.
  - Outputs hold stable while res_valid=1 and no pop occurs.
  - When empty, res_class, res_margin and res_low_conf read 0.
- Counters: cnt0/cnt1 increment by 1 on each accepted push of that class and saturate at all-ones.
- stat_clr: at the next edge, clears cnt0, cnt1, overflow and pair_err.
  - If an event occurs in the same cycle, the clear wins.
  - FIFO and slots are unaffected.
- Reset mid-operation: any partial pair and all queued results are lost. No output glitches beyond returning to reset values.

Decomposition:
- Shared package (e.g. dnn_pkg):
  - SCORE_W=17 localparam.
  - typedef struct packed {logic cls; logic [MARGIN_W-1:0] margin; logic low_conf;} class_res_t.
  - The 18-bit diff typedef.
- One natural sub-module: result_fifo.
  - Parameterised by DEPTH and entry width.
  - Ports: push, pop, din, dout, empty, full.
- Capture/compare logic and counters stay in the top module.

Test Plan:
- Simultaneous readies, in0=100, in1=-50 → two cycles later res_valid=1, class=0, margin=150, low_conf=0; cnt0=1.
- in1_ready with in1=40 in cycle 5, in0_ready with in0=35 in cycle 9 → push in cycle 10, class=1, margin=5, low_conf=1.
- in0=65535, in1=-65536 → mag=131071, margin saturates to 4095, class=0; tie in0=in1=7 → class=0, margin=0, low_conf=1.
- Five pairs pushed with res_ack held 0 and DEPTH=4 → 4 queued, overflow=1 after the 5th, cnt total=4. Then ack 4 times → results pop in order and res_valid drops.
- FIFO full with res_ack=1 in the same cycle as a push → no overflow and occupancy stays 4. Separately, two in0_ready pulses with no in1 → pair_err=1 and the second in0 value is used.
- rst_n asserted asynchronously mid-cycle with 2 queued and slot0 full → all outputs 0 immediately. A subsequent stat_clr asserted alongside a push clears the counters, leaving cnt=0.
